// File: rtl/pe_multicaster.sv
// Column multicast controller: a tag-filtered forward FIFO to one PE, a psum
// return skid buffer, and a column ID that can be reloaded at run time.
module pe_multicaster #(
   parameter  int DATA_WIDTH = 16,
   parameter  int NUM_COL    = 4,
   parameter  int FIFO_DEPTH = 2,
   localparam int IDW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
   localparam int DW  = DATA_WIDTH,
   localparam int PW  = 2 * DATA_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           id_cfg_en,
   input  logic [IDW-1:0] id_cfg,
   input  logic           bus_valid,
   output logic           bus_ready,
   input  logic [IDW-1:0] bus_tag,
   input  logic           bus_bcast,
   input  logic [2:0]     bus_sel,
   input  logic [DW-1:0]  bus_ifmap,
   input  logic [DW-1:0]  bus_fltr,
   input  logic [PW-1:0]  bus_psum,
   output logic           pe_valid,
   input  logic           pe_ready,
   output logic [2:0]     pe_sel,
   output logic [DW-1:0]  pe_ifmap,
   output logic [DW-1:0]  pe_fltr,
   output logic [PW-1:0]  pe_psum,
   input  logic           pe_opsum_valid,
   output logic           pe_opsum_ready,
   input  logic [PW-1:0]  pe_opsum,
   output logic           bus_opsum_valid,
   input  logic           bus_opsum_ready,
   output logic [PW-1:0]  bus_opsum,
   output logic [IDW-1:0] cur_id
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [2:0]    sel;
      logic [DW-1:0] ifmap;
      logic [DW-1:0] fltr;
      logic [PW-1:0] psum;
   } pkt_t;

   typedef enum logic [1:0] {
      UNCFG,
      ACTIVE,
      DRAIN
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [IDW-1:0] id_q;
   logic [IDW-1:0] id_d;
   logic [IDW-1:0] pend_q;
   logic [IDW-1:0] pend_d;

   pkt_t           fmem [FIFO_DEPTH];
   logic [AW-1:0]  f_wr;
   logic [AW-1:0]  f_rd;
   logic [CW-1:0]  f_cnt;
   logic           f_empty;
   logic           f_full;
   logic           f_push;
   logic           f_pop;
   logic           hit;
   pkt_t           f_in;
   pkt_t           f_head;

   logic [PW-1:0]  rmem [2];
   logic           r_wr;
   logic           r_rd;
   logic [1:0]     r_cnt;
   logic [1:0]     r_cnt_d;
   logic           r_push;
   logic           r_pop;
   logic           r_rdy;

   assign f_empty = (f_cnt == '0);
   assign f_full  = (f_cnt == CW'(FIFO_DEPTH));

   // ID reload waits for in-flight packets so none are delivered
   // under a column ID they were not filtered against.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      pend_d    = pend_q;
      bus_ready = 1'b0;
      unique case (state_q)
         UNCFG: begin
            if (id_cfg_en) begin
               id_d    = id_cfg;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            bus_ready = !f_full;
            if (id_cfg_en) begin
               if (f_empty) begin
                  id_d = id_cfg;
               end else begin
                  pend_d  = id_cfg;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (id_cfg_en) pend_d = id_cfg;
            if (f_empty) begin
               id_d    = pend_d;
               state_d = ACTIVE;
            end
         end
         default: state_d = UNCFG;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= UNCFG;
         id_q    <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         pend_q  <= pend_d;
      end
   end

   assign cur_id = id_q;

   assign hit    = (bus_bcast | (bus_tag == id_q)) & (|bus_sel);
   assign f_push = bus_valid & bus_ready & hit;
   assign f_pop  = pe_valid & pe_ready;

   assign f_in.sel   = bus_sel;
   assign f_in.ifmap = bus_ifmap;
   assign f_in.fltr  = bus_fltr;
   assign f_in.psum  = bus_psum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fmem[i] <= '0;
         f_wr  <= '0;
         f_rd  <= '0;
         f_cnt <= '0;
      end else begin
         if (f_push) begin
            fmem[f_wr] <= f_in;
            f_wr       <= f_wr + AW'(1);
         end
         if (f_pop) f_rd <= f_rd + AW'(1);
         case ({f_push, f_pop})
            2'b10:   f_cnt <= f_cnt + CW'(1);
            2'b01:   f_cnt <= f_cnt - CW'(1);
            default: f_cnt <= f_cnt;
         endcase
      end
   end

   assign f_head   = fmem[f_rd];
   assign pe_valid = !f_empty;
   assign pe_sel   = f_head.sel;
   assign pe_ifmap = f_head.ifmap;
   assign pe_fltr  = f_head.fltr;
   assign pe_psum  = f_head.psum;

   // Return path: two entries keep full throughput with a registered ready.
   assign r_push = pe_opsum_valid & r_rdy;
   assign r_pop  = bus_opsum_valid & bus_opsum_ready;

   always_comb begin
      r_cnt_d = r_cnt;
      case ({r_push, r_pop})
         2'b10:   r_cnt_d = r_cnt + 2'd1;
         2'b01:   r_cnt_d = r_cnt - 2'd1;
         default: r_cnt_d = r_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rmem[0] <= '0;
         rmem[1] <= '0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_cnt   <= '0;
         r_rdy   <= 1'b1;
      end else begin
         if (r_push) begin
            rmem[r_wr] <= pe_opsum;
            r_wr       <= ~r_wr;
         end
         if (r_pop) r_rd <= ~r_rd;
         r_cnt <= r_cnt_d;
         r_rdy <= (r_cnt_d != 2'd2);
      end
   end

   assign pe_opsum_ready  = r_rdy;
   assign bus_opsum_valid = (r_cnt != 2'd0);
   assign bus_opsum       = rmem[r_rd];

endmodule
